dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data RAM between two requesters.
- Port 0 is the pipeline MEM stage (load/store path). Port 1 is the loader/debug DMA port used for program load and memory inspection.
- Port 0 has priority. Port 1 is protected from starvation by a wait counter.
- Stall to the pipeline is generated whenever port 0 is denied. Each read response is routed back to the port that issued it.

Parameters:
- ADDR_W, 32, byte address width (`DataAddrBus`)
- DATA_W, 32, data width (`DataBus`)
- MAX_WAIT, 4, consecutive denied cycles before port 1 is forced a grant; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- p0_req  in  1  port 0 access request
- p0_we  in  1  port 0 write (1) / read (0)
- p0_be  in  4  port 0 byte enables
- p0_addr  in  ADDR_W  port 0 address
- p0_wdata  in  DATA_W  port 0 write data
- p0_ready  out  1  port 0 granted this cycle
- p0_rvalid  out  1  port 0 read data valid
- p0_rdata  out  DATA_W  port 0 read data
- p1_req, p1_we, p1_be, p1_addr, p1_wdata  in  same as port 0  port 1 request
- p1_ready, p1_rvalid, p1_rdata  out  same as port 0  port 1 response
- stall  out  1  p0_req & ~p0_ready, to the pipeline controller
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_be  out  4  RAM byte-lane enables
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read access

Behaviour:
- Handshake:
  - A requester holds req/we/be/addr/wdata stable until it samples ready=1 at a rising edge.
  - A transfer occurs on req & ready.
  - ready is combinational from the current req inputs and registered state, with no combinational path from ram_rdata.
- Grant, evaluated each cycle:
  - force1 = (wait_cnt == MAX_WAIT).
  - gnt1 = p1_req & (force1 | ~p0_req).
  - gnt0 = p0_req & ~gnt1.
  - At most one grant per cycle.
- RAM mux:
  - ram_en = gnt0 | gnt1.
  - ram_we/be/addr/wdata come from the granted port.
  - When there is no grant, ram_we = 0, ram_be = 0, ram_addr = 0, ram_wdata = 0.
- wait_cnt (4-bit register):
  - Cleared when ~p1_req or gnt1.
  - Otherwise increments, saturating at MAX_WAIT.
  - Port 0 is therefore denied for exactly one cycle per MAX_WAIT+1 cycles of continuous contention.
- Read return tracking, registered:
  - rd_pend <= ram_en & ~ram_we.
  - rd_sel <= gnt1.
  - Cycle N+1 after a read grant in cycle N: rvalid of the selected port = 1, that port's rdata = ram_rdata, and the other port's rvalid = 0.
  - Non-selected rdata and idle rdata drive zero.
- Writes produce no rvalid and complete at the grant edge.
- Back-to-back:
  - A new grant may issue in the same cycle a previous read is being returned, giving full throughput of 1 access/cycle.
  - A read in N followed by a write in N+1 is legal. The read data still returns in N+1 to the correct port.
- Reset (rst=1 at a rising edge):
  - wait_cnt = 0, rd_pend = 0, rd_sel = 0.
  - While rst is high, all grants are suppressed: every ready = 0, ram_en = 0, all rvalid = 0, all rdata = 0, stall = p0_req.
  - A read granted in the cycle reset asserts gets no rvalid.
- Byte-lane formatting and sign extension are not done here; they belong to the MEM stage. be is passed through unchanged.

Decomposition:
- Shared define file adds `MemPortBus` [3:0] (byte enables), `MaxWaitDef`, and port-select constants `PortMem` = 1'b0, `PortDma` = 1'b1.
- The existing `Enabled`, `Disabled`, `Zero`, `DataBus` and `DataAddrBus` are reused.
- One natural sub-module, dmem_arb_wait, holds the wait_cnt saturating counter and the force1 output. Everything else stays flat.

Test Plan:
- p0 read only, addr 0x10, RAM holds 0xDEADBEEF at 0x10 -> p0_ready=1 same cycle, stall=0; next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF; p1_rvalid=0.
- p0 and p1 request continuously, MAX_WAIT=4 -> grants follow P0,P0,P0,P0,P1 repeating; stall=1 exactly on every 5th cycle.
- p1 only, write 0xCAFEF00D to 0x20 with be=4'b1111, then p0 reads 0x20 -> ram_we=1 during the p1 grant and no rvalid for it; the p0 read then returns 0xCAFEF00D.
- Alternating reads p0@0x0 and p1@0x4 on consecutive cycles, with contention forced by MAX_WAIT=1 -> each rvalid appears only on the issuing port, one cycle after its grant, with the correct data.
- rst asserted in the cycle a p1 read is granted, released the next cycle -> no p1_rvalid, wait_cnt=0, p0 wins the first post-reset cycle.
- p1_req dropped mid-wait at wait_cnt=3, then reasserted -> counter restarts from 0 and p1 is forced only after 4 further denied cycles.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and helpers for the data-memory arbiter: bus widths,
// byte-lane type, wait-counter sizing and port-select encodings.
package dmem_arbiter_pkg;

    localparam int DATA_BUS_W   = 32;
    localparam int ADDR_BUS_W   = 32;
    localparam int MEM_PORT_W   = 4;
    localparam int MAX_WAIT_DEF = 4;
    localparam int WAIT_W       = 4;

    localparam logic ENABLED  = 1'b1;
    localparam logic DISABLED = 1'b0;

    // Encoding of the registered read-return selector
    localparam logic PORT_MEM = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef logic [MEM_PORT_W-1:0] mem_port_bus_t;
    typedef logic [WAIT_W-1:0]     wait_cnt_t;

    function automatic wait_cnt_t wait_inc(input wait_cnt_t cnt, input wait_cnt_t lim);
        if (cnt >= lim) begin
            return lim;
        end else begin
            return cnt + 4'd1;
        end
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's view of the shared data RAM: request bundle in,
// grant plus routed read response out.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_BUS_W,
    parameter int DATA_W = DATA_BUS_W
);
    logic              req;
    logic              we;
    mem_port_bus_t     be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arb_wait.sv
// Starvation guard for the DMA port: counts consecutive denied cycles and
// raises force1 once the count reaches MAX_WAIT.
module dmem_arb_wait
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic p1_req,
    input  logic gnt1,
    output logic force1
);

    localparam wait_cnt_t MAX_LIM = wait_cnt_t'(MAX_WAIT);

    wait_cnt_t wait_cnt_r;

    // Saturating denied-cycle counter, restarted whenever port 1 is idle or served
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 4'h0;
        end else if (!p1_req || gnt1) begin
            wait_cnt_r <= 4'h0;
        end else begin
            wait_cnt_r <= wait_inc(wait_cnt_r, MAX_LIM);
        end
    end

    assign force1 = (wait_cnt_r == MAX_LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: pipeline MEM stage
// has priority, the DMA port is guaranteed service after MAX_WAIT denials.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_BUS_W,
    parameter int DATA_W   = DATA_BUS_W,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic              stall,
    output logic              ram_en,
    output logic              ram_we,
    output mem_port_bus_t     ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic force1_s;
    logic gnt0_s;
    logic gnt1_s;
    logic rd_pend_r;
    logic rd_sel_r;
    logic p0_rvalid_s;
    logic p1_rvalid_s;

    dmem_arb_wait #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk    (clk),
        .rst    (rst),
        .p1_req (p1.req),
        .gnt1   (gnt1_s),
        .force1 (force1_s)
    );

    // Grant decision; reset suppresses every grant
    always_comb begin
        gnt0_s = DISABLED;
        gnt1_s = DISABLED;
        if (rst) begin
            gnt0_s = DISABLED;
            gnt1_s = DISABLED;
        end else begin
            gnt1_s = p1.req & (force1_s | ~p0.req);
            gnt0_s = p0.req & ~gnt1_s;
        end
    end

    // RAM request mux; an idle RAM sees an all-zero command
    always_comb begin
        ram_en    = gnt0_s | gnt1_s;
        ram_we    = DISABLED;
        ram_be    = {MEM_PORT_W{1'b0}};
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = {DATA_W{1'b0}};
        case ({gnt1_s, gnt0_s})
            2'b10: begin
                ram_we    = p1.we;
                ram_be    = p1.be;
                ram_addr  = p1.addr;
                ram_wdata = p1.wdata;
            end
            2'b01: begin
                ram_we    = p0.we;
                ram_be    = p0.be;
                ram_addr  = p0.addr;
                ram_wdata = p0.wdata;
            end
            default: begin
                ram_we    = DISABLED;
                ram_be    = {MEM_PORT_W{1'b0}};
                ram_addr  = {ADDR_W{1'b0}};
                ram_wdata = {DATA_W{1'b0}};
            end
        endcase
    end

    // Remember which port owns the read data arriving next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_r <= DISABLED;
            rd_sel_r  <= PORT_MEM;
        end else begin
            rd_pend_r <= ram_en & ~ram_we;
            rd_sel_r  <= gnt1_s;
        end
    end

    // Returned data is steered only to the issuer; it never feeds back into ready
    assign p0_rvalid_s = rd_pend_r & ~rst & (rd_sel_r == PORT_MEM);
    assign p1_rvalid_s = rd_pend_r & ~rst & (rd_sel_r == PORT_DMA);

    assign p0.ready  = gnt0_s;
    assign p1.ready  = gnt1_s;
    assign p0.rvalid = p0_rvalid_s;
    assign p1.rvalid = p1_rvalid_s;
    assign p0.rdata  = p0_rvalid_s ? ram_rdata : {DATA_W{1'b0}};
    assign p1.rdata  = p1_rvalid_s ? ram_rdata : {DATA_W{1'b0}};
    assign stall     = p0.req & ~gnt0_s;

endmodule
